// File: rtl/fifo_pkg.sv
// Shared helpers for the single-clock FIFO family.
//   addr_w(depth) : address bits needed to index 'depth' entries
//   cnt_w(depth)  : pointer/occupancy width (address bits plus a wrap bit)
//   is_pow2(v)    : true for powers of two >= 2
//   RD_MODE_*     : read-mode selector values for the FWFT parameter
package fifo_pkg;

  localparam int RD_MODE_FWFT = 1;
  localparam int RD_MODE_REG  = 0;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_mem_sp.sv
// Storage array for the FIFO: DEPTH x DATA_W entries.
// One synchronous write port, one asynchronous (combinational) read port.
// Contents are never reset.
//   clk     : write clock
//   we      : write enable
//   waddr   : write address
//   wdata   : write data
//   raddr   : read address
//   rdata   : read data, combinational from raddr
module fifo_mem_sp
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [addr_w(DEPTH)-1:0]  waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [addr_w(DEPTH)-1:0]  raddr,
  output logic [DATA_W-1:0]         rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, full/empty and
// almost-full/almost-empty flags, sticky overflow/underflow, synchronous
// flush and a selectable read mode (first-word-fall-through or registered).
//   clk          : clock, all state updates on posedge
//   reset_n      : asynchronous active-low reset
//   flush        : synchronous clear of contents and error flags
//   wr_en/wr_data: write request and data
//   rd_en        : read (pop) request
//   rd_data      : read data
//   rd_valid     : FWFT=1: head word present; FWFT=0: one-cycle pulse after a pop
//   full/empty   : count == DEPTH / count == 0
//   almost_full  : count >= AF_THRESH
//   almost_empty : count <= AE_THRESH
//   count        : occupancy 0..DEPTH
//   overflow     : sticky, a write was rejected
//   underflow    : sticky, a read was rejected
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = RD_MODE_FWFT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int CNT_W  = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] AF_LVL = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_LVL = CNT_W'(AE_THRESH);

  // Elaboration-time parameter legality
  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 2");
  end
  if (!(AE_THRESH >= 0 && AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
    $error("sync_fifo_param: need 0 <= AE_THRESH < AF_THRESH <= DEPTH");
  end
  if (FWFT != RD_MODE_FWFT && FWFT != RD_MODE_REG) begin : g_bad_mode
    $error("sync_fifo_param: FWFT must be 0 or 1");
  end
  if (DATA_W < 1) begin : g_bad_width
    $error("sync_fifo_param: DATA_W must be >= 1");
  end

  logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [CNT_W-1:0]  cnt_w_s;
  logic              full_s, empty_s;
  logic              rd_acc, wr_acc;
  logic [DATA_W-1:0] mem_rdata;

  // Wrap bit differs with equal address bits only when a full lap ahead.
  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[CNT_W-1] != rd_ptr_q[CNT_W-1]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign cnt_w_s = wr_ptr_q - rd_ptr_q;

  // No bypass: a read on an empty FIFO is rejected even if a write lands.
  // A write on a full FIFO succeeds when a read frees the slot that cycle.
  assign rd_acc = rd_en & ~empty_s;
  assign wr_acc = wr_en & (~full_s | rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (flush) begin
      // Accesses presented alongside flush are dropped silently.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + CNT_W'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + CNT_W'(1);
      ovf_d = ovf_q | (wr_en & ~wr_acc);
      unf_d = unf_q | (rd_en & ~rd_acc);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_mem_sp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc & ~flush),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (mem_rdata)
  );

  assign count        = cnt_w_s;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (cnt_w_s >= AF_LVL);
  assign almost_empty = (cnt_w_s <= AE_LVL);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  if (FWFT == RD_MODE_FWFT) begin : g_fwft
    assign rd_data  = mem_rdata;
    assign rd_valid = ~empty_s;
  end else begin : g_reg
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    // rd_data keeps the last popped word; rd_valid is a one-cycle pulse.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc & ~flush;
        if (rd_acc && !flush) rd_data_q <= mem_rdata;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;

  logic [DW-1:0] f_rd_data, r_rd_data;
  logic          f_rd_valid, r_rd_valid;
  logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic          r_full, r_empty, r_af, r_ae, r_ovf, r_unf;
  logic [4:0]    f_count, r_count;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] model_q [$];
  logic [DW-1:0] exp_f [$];
  logic [DW-1:0] exp_r [$];
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;
  bit            m_rv_next = 1'b0;
  logic [DW-1:0] last_r = '0;
  logic [DW-1:0] mon_x;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) dut_f (
    .clk(clk), .reset_n(reset_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full),
    .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf)
  );

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) dut_r (
    .clk(clk), .reset_n(reset_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(r_rd_data), .rd_valid(r_rd_valid), .full(r_full),
    .empty(r_empty), .almost_full(r_af), .almost_empty(r_ae), .count(r_count),
    .overflow(r_ovf), .underflow(r_unf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_state(input int c, input bit ovf, input bit unf, input bit rv);
    chk("f_count", 32'(f_count), 32'(c));
    chk("f_full",  32'(f_full),  32'(c == DEPTH));
    chk("f_empty", 32'(f_empty), 32'(c == 0));
    chk("f_af",    32'(f_af),    32'(c >= AF));
    chk("f_ae",    32'(f_ae),    32'(c <= AE));
    chk("f_ovf",   32'(f_ovf),   32'(ovf));
    chk("f_unf",   32'(f_unf),   32'(unf));
    chk("f_rvld",  32'(f_rd_valid), 32'(c != 0));
    chk("r_count", 32'(r_count), 32'(c));
    chk("r_full",  32'(r_full),  32'(c == DEPTH));
    chk("r_empty", 32'(r_empty), 32'(c == 0));
    chk("r_af",    32'(r_af),    32'(c >= AF));
    chk("r_ae",    32'(r_ae),    32'(c <= AE));
    chk("r_ovf",   32'(r_ovf),   32'(ovf));
    chk("r_unf",   32'(r_unf),   32'(unf));
    chk("r_rvld",  32'(r_rd_valid), 32'(rv));
  endtask

  task automatic check_reset();
    check_state(0, 1'b0, 1'b0, 1'b0);
    chk("r_rdata_rst", 32'(r_rd_data), 32'h0);
  endtask

  // Called at posedge+1; drives one cycle, updates the model, checks state.
  task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r, input bit f);
    int  c;
    bit  eo, eu, erv, racc, wacc;
    logic [DW-1:0] x;
    wr_en = w; wr_data = d; rd_en = r; flush = f;
    c = model_q.size(); eo = m_ovf; eu = m_unf; erv = m_rv_next;
    racc = r && (c > 0);
    wacc = w && ((c < DEPTH) || racc);
    if (f) begin
      model_q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_rv_next = 1'b0;
    end else begin
      m_rv_next = racc;
      if (racc) begin
        x = model_q.pop_front();
        exp_f.push_back(x);
        exp_r.push_back(x);
      end
      if (wacc) model_q.push_back(d);
      if (w && !wacc) m_ovf = 1'b1;
      if (r && !racc) m_unf = 1'b1;
    end
    @(negedge clk);
    check_state(c, eo, eu, erv);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: pops expected words when each DUT presents read data.
  always @(negedge clk) begin
    if (!reset_n) begin
      last_r = '0;
    end else begin
      if (rd_en && !flush && f_rd_valid) begin
        if (exp_f.size() == 0) begin
          total++; bad++;
          $display("FAIL f_unexpected_pop actual=%0h required=none", f_rd_data);
        end else begin
          mon_x = exp_f.pop_front();
          chk("f_rdata", 32'(f_rd_data), 32'(mon_x));
        end
      end
      if (r_rd_valid) begin
        if (exp_r.size() == 0) begin
          total++; bad++;
          $display("FAIL r_unexpected_pop actual=%0h required=none", r_rd_data);
        end else begin
          mon_x = exp_r.pop_front();
          chk("r_rdata", 32'(r_rd_data), 32'(mon_x));
          last_r = mon_x;
        end
      end else begin
        chk("r_rdata_hold", 32'(r_rd_data), 32'(last_r));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    #2 reset_n = 1'b0;
    #1 check_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Fill 0x00..0x0F
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
    // Full + simultaneous write/read: both accepted, no overflow
    cycle(1'b1, 8'h10, 1'b1, 1'b0);
    // Rejected write
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    // Drain, then one extra read
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    // Empty + simultaneous write/read: write only, underflow set
    cycle(1'b1, 8'h33, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Wrap-around with occupancy held at 3
    for (int i = 0; i < 3; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, DW'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Registered-read latency and hold
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0);

    // Flush with count=9, overflow=1 and a write pending
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 8'h77, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle(1'(($urandom % 3) != 0), DW'($urandom), 1'($urandom % 2), 1'(($urandom % 60) == 0));

    // Asynchronous reset mid-stream
    for (int i = 0; i < 6; i++) cycle(1'b1, DW'($urandom), 1'(i == 5), 1'b0);
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_reset();
    model_q.delete(); exp_f.delete(); exp_r.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_rv_next = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;

    for (int i = 0; i < 200; i++)
      cycle(1'($urandom % 2), DW'($urandom), 1'($urandom % 2), 1'b0);
    while (model_q.size() != 0) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("f_pending", 32'(exp_f.size()), 32'h0);
    chk("r_pending", 32'(exp_r.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
